// File: rtl/seq_proc.sv
// -----------------------------------------------------------------------------
// seq_proc -- parametrised fetch/execute accumulator processor
//
// Runs a program at addresses 0..PROG_LEN-1 through one external read port and
// executes a small accumulator ISA (NOP, OUTM, LDA, ADD, OUTA, JMP, JZ, HALT).
// Results leave on a valid/ready port; the core stalls while the consumer
// applies backpressure.
//
// Parameters
//   DATA_W    instruction/data width; opcode = instr[DATA_W-1:ADDR_W]
//   ADDR_W    memory address width;   operand = instr[ADDR_W-1:0]
//   PROG_LEN  program length; pc wraps PROG_LEN-1 -> 0
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   en         in   run enable; low holds the core in FETCH
//   mem_addr   out  memory read address (combinational from state)
//   mem_rdata  in   read data, valid in the same cycle as mem_addr
//   out        out  output data, stable while out_valid is high
//   out_valid  out  out holds a new value
//   out_ready  in   consumer accepts out when out_valid & out_ready
//   halted     out  core has executed HALT
//   trap       out  unknown opcode seen (only with SEQ_PROC_TRAP_EN)
//
// Configuration macro: SEQ_PROC_TRAP_EN
//   defined   -> unknown opcodes raise trap and halt with pc at the fault
//   undefined -> unknown opcodes execute as NOP
// -----------------------------------------------------------------------------
module seq_proc #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int PROG_LEN = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              halted
`ifdef SEQ_PROC_TRAP_EN
    ,
    output logic              trap
`endif
);

    localparam int OP_W = DATA_W - ADDR_W;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [OP_W-1:0] OPC_NOP  = OP_W'(8'h00);
    localparam logic [OP_W-1:0] OPC_OUTM = OP_W'(8'h01);
    localparam logic [OP_W-1:0] OPC_LDA  = OP_W'(8'h02);
    localparam logic [OP_W-1:0] OPC_ADD  = OP_W'(8'h03);
    localparam logic [OP_W-1:0] OPC_OUTA = OP_W'(8'h04);
    localparam logic [OP_W-1:0] OPC_JMP  = OP_W'(8'h05);
    localparam logic [OP_W-1:0] OPC_JZ   = OP_W'(8'h06);
    localparam logic [OP_W-1:0] OPC_HALT = {OP_W{1'b1}};

    logic [1:0]        state_r, state_s;
    logic [ADDR_W-1:0] pc_r, pc_s;
    logic [DATA_W-1:0] acc_r, acc_s;
    logic [DATA_W-1:0] ir_r, ir_s;
    logic [DATA_W-1:0] out_r, out_s;
    logic              out_valid_r, out_valid_s;
    logic              halted_r, halted_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [OP_W-1:0]   opcode_s;
    logic [ADDR_W-1:0] operand_s;
`ifdef SEQ_PROC_TRAP_EN
    logic              trap_r, trap_s;
`endif

    // Sequential successor of the program counter, wrapping at PROG_LEN-1.
    function automatic logic [ADDR_W-1:0] pc_seq(input logic [ADDR_W-1:0] p);
        if (p == ADDR_W'(PROG_LEN - 1)) begin
            return {ADDR_W{1'b0}};
        end else begin
            return p + ADDR_W'(1);
        end
    endfunction

    // Jump target; targets outside the program restart it at address 0.
    function automatic logic [ADDR_W-1:0] pc_jump(input logic [ADDR_W-1:0] op);
        if ({1'b0, op} < (ADDR_W + 1)'(PROG_LEN)) begin
            return op;
        end else begin
            return {ADDR_W{1'b0}};
        end
    endfunction

    assign opcode_s  = ir_r[DATA_W-1:ADDR_W];
    assign operand_s = ir_r[ADDR_W-1:0];

    // Next-state and datapath decode for all architectural registers.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        acc_s       = acc_r;
        ir_s        = ir_r;
        out_s       = out_r;
        out_valid_s = out_valid_r;
        halted_s    = halted_r;
        mem_addr_s  = pc_r;
`ifdef SEQ_PROC_TRAP_EN
        trap_s      = trap_r;
`endif
        case (state_r)
            ST_FETCH: begin
                if (en) begin
                    ir_s    = mem_rdata;
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                // Memory is addressed by the operand so data-reading opcodes
                // see mem[op] on mem_rdata in this same cycle.
                mem_addr_s = operand_s;
                state_s    = ST_FETCH;
                pc_s       = pc_seq(pc_r);
                case (opcode_s)
                    OPC_NOP: begin
                        pc_s = pc_seq(pc_r);
                    end
                    OPC_OUTM: begin
                        out_s       = mem_rdata;
                        out_valid_s = 1'b1;
                        pc_s        = pc_r;
                        state_s     = ST_WAIT;
                    end
                    OPC_LDA: begin
                        acc_s = mem_rdata;
                    end
                    OPC_ADD: begin
                        acc_s = acc_r + mem_rdata;
                    end
                    OPC_OUTA: begin
                        out_s       = acc_r;
                        out_valid_s = 1'b1;
                        pc_s        = pc_r;
                        state_s     = ST_WAIT;
                    end
                    OPC_JMP: begin
                        pc_s = pc_jump(operand_s);
                    end
                    OPC_JZ: begin
                        if (acc_r == {DATA_W{1'b0}}) begin
                            pc_s = pc_jump(operand_s);
                        end else begin
                            pc_s = pc_seq(pc_r);
                        end
                    end
                    OPC_HALT: begin
                        halted_s = 1'b1;
                        pc_s     = pc_r;
                        state_s  = ST_HALT;
                    end
                    default: begin
`ifdef SEQ_PROC_TRAP_EN
                        trap_s   = 1'b1;
                        halted_s = 1'b1;
                        pc_s     = pc_r;
                        state_s  = ST_HALT;
`else
                        pc_s     = pc_seq(pc_r);
`endif
                    end
                endcase
            end
            ST_WAIT: begin
                // pc advances only once the consumer has taken the value.
                if (out_valid_r && out_ready) begin
                    out_valid_s = 1'b0;
                    pc_s        = pc_seq(pc_r);
                    state_s     = ST_FETCH;
                end else begin
                    state_s     = ST_WAIT;
                end
            end
            ST_HALT: begin
                state_s = ST_HALT;
            end
            default: begin
                state_s = ST_FETCH;
            end
        endcase
    end

    // Architectural register update with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_FETCH;
            pc_r        <= {ADDR_W{1'b0}};
            acc_r       <= {DATA_W{1'b0}};
            ir_r        <= {DATA_W{1'b0}};
            out_r       <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
            halted_r    <= 1'b0;
`ifdef SEQ_PROC_TRAP_EN
            trap_r      <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            acc_r       <= acc_s;
            ir_r        <= ir_s;
            out_r       <= out_s;
            out_valid_r <= out_valid_s;
            halted_r    <= halted_s;
`ifdef SEQ_PROC_TRAP_EN
            trap_r      <= trap_s;
`endif
        end
    end

    assign mem_addr  = mem_addr_s;
    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign halted    = halted_r;
`ifdef SEQ_PROC_TRAP_EN
    assign trap      = trap_r;
`endif

endmodule

// File: tb/tb_seq_proc.sv
// -----------------------------------------------------------------------------
// tb_seq_proc -- self-checking bench for seq_proc (default parameters)
//
// Directed scenarios cover reset, output timing, carry drop, backpressure,
// branches, HALT, asynchronous reset and unknown opcodes. Random programs are
// then run with random en/out_ready and compared against an instruction-level
// interpreter of the ISA kept in this file.
// -----------------------------------------------------------------------------
module tb_seq_proc;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 8;
    localparam int PROG_LEN = 10;

    logic              clk;
    logic              rst;
    logic              en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] out;
    logic              out_valid;
    logic              out_ready;
    logic              halted;
`ifdef SEQ_PROC_TRAP_EN
    logic              trap;
`endif

    logic [DATA_W-1:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;

    // Interpreter state
    int                m_pc;
    logic [DATA_W-1:0] m_acc;
    bit                m_halt;
    bit                m_trap;

    seq_proc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PROG_LEN(PROG_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .halted    (halted)
`ifdef SEQ_PROC_TRAP_EN
        ,
        .trap      (trap)
`endif
    );

    assign mem_rdata = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        #2;
        check_eq("rst_out", 32'(out), 32'h0);
        check_eq("rst_valid", 32'(out_valid), 32'h0);
        check_eq("rst_halted", 32'(halted), 32'h0);
        check_eq("rst_addr", 32'(mem_addr), 32'h0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Executes instructions until one produces an output or the program halts.
    task automatic model_next(output bit got, output logic [DATA_W-1:0] val);
        logic [DATA_W-1:0] ins;
        int opc;
        int op;
        int nxt;
        got = 1'b0;
        val = 16'h0000;
        for (int s = 0; s < 4000; s++) begin
            if (m_halt || got) break;
            ins = mem[m_pc];
            opc = int'(ins[15:8]);
            op  = int'(ins[7:0]);
            nxt = (m_pc + 1) % PROG_LEN;
            case (opc)
                8'h00: ;
                8'h01: begin val = mem[op]; got = 1'b1; end
                8'h02: m_acc = mem[op];
                8'h03: m_acc = m_acc + mem[op];
                8'h04: begin val = m_acc; got = 1'b1; end
                8'h05: nxt = (op < PROG_LEN) ? op : 0;
                8'h06: if (m_acc == 16'h0000) nxt = (op < PROG_LEN) ? op : 0;
                8'hFF: m_halt = 1'b1;
                default: begin
`ifdef SEQ_PROC_TRAP_EN
                    m_halt = 1'b1;
                    m_trap = 1'b1;
`endif
                end
            endcase
            if (!m_halt) m_pc = nxt;
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_instr();
        int r;
        logic [7:0] opc;
        logic [7:0] op;
        r  = int'($urandom_range(0, 19));
        op = 8'($urandom_range(0, 255));
        if (r <= 1)       opc = 8'h00;
        else if (r <= 4)  opc = 8'h01;
        else if (r <= 7)  opc = 8'h02;
        else if (r <= 10) opc = 8'h03;
        else if (r <= 12) opc = 8'h04;
        else if (r <= 14) begin opc = 8'h05; op = 8'($urandom_range(0, 15)); end
        else if (r <= 16) begin opc = 8'h06; op = 8'($urandom_range(0, 15)); end
        else if (r == 18) opc = 8'h7A;
        else              opc = 8'hFF;
        return {opc, op};
    endfunction

    initial begin
        bit                got;
        logic [DATA_W-1:0] exp_v;
        bit                stalled_prev;
        logic [DATA_W-1:0] prev_out;
        logic [ADDR_W-1:0] prev_addr;

        rst = 1'b0;
        en = 1'b0;
        out_ready = 1'b0;

        // OUTM of a constant, en gating, then wrap back to the same OUTM.
        do_reset();
        mem[0] = 16'h0105;
        mem[5] = 16'hBEEF;
        en = 1'b0;
        tick(3);
        check_eq("en_low_addr", 32'(mem_addr), 32'h0);
        check_eq("en_low_valid", 32'(out_valid), 32'h0);
        en = 1'b1;
        tick(2);
        check_eq("t1_valid", 32'(out_valid), 32'h1);
        check_eq("t1_out", 32'(out), 32'hBEEF);
        tick(1);
        check_eq("t1_valid_drop", 32'(out_valid), 32'h0);
        check_eq("t1_out_hold", 32'(out), 32'hBEEF);
        check_eq("t1_pc1", 32'(mem_addr), 32'h1);
        tick(18);
        check_eq("t1_wrap", 32'(mem_addr), 32'h0);
        tick(2);
        check_eq("t1_again", 32'(out_valid), 32'h1);

        // LDA/ADD overflow, OUTA, then HALT.
        do_reset();
        mem[0] = 16'h0220;
        mem[1] = 16'h0321;
        mem[2] = 16'h0400;
        mem[3] = 16'hFF00;
        mem[8'h20] = 16'hFFFF;
        mem[8'h21] = 16'h0002;
        tick(6);
        check_eq("t2_valid", 32'(out_valid), 32'h1);
        check_eq("t2_out", 32'(out), 32'h0001);
        tick(3);
        check_eq("t2_halted", 32'(halted), 32'h1);
        check_eq("t2_halt_addr", 32'(mem_addr), 32'h3);
        tick(5);
        check_eq("t2_halt_stay", 32'(mem_addr), 32'h3);
        check_eq("t2_out_keep", 32'(out), 32'h0001);

        // Backpressure on OUTM.
        do_reset();
        mem[0] = 16'h0105;
        mem[5] = 16'h1234;
        out_ready = 1'b0;
        tick(2);
        for (int i = 0; i < 5; i++) begin
            check_eq("t3_stall_valid", 32'(out_valid), 32'h1);
            check_eq("t3_stall_out", 32'(out), 32'h1234);
            check_eq("t3_stall_addr", 32'(mem_addr), 32'h0);
            tick(1);
        end
        out_ready = 1'b1;
        tick(1);
        check_eq("t3_release_valid", 32'(out_valid), 32'h0);
        check_eq("t3_release_pc", 32'(mem_addr), 32'h1);

        // JZ taken, JZ not taken, JMP beyond the program.
        do_reset();
        mem[0] = 16'h0607;
        mem[7] = 16'h0230;
        mem[8] = 16'h0607;
        mem[9] = 16'h0540;
        mem[8'h30] = 16'h0003;
        tick(2);
        check_eq("t4_jz_taken", 32'(mem_addr), 32'h7);
        tick(4);
        check_eq("t4_jz_not", 32'(mem_addr), 32'h9);
        tick(2);
        check_eq("t4_jmp_oob", 32'(mem_addr), 32'h0);

        // Asynchronous reset while an output waits.
        do_reset();
        mem[0] = 16'h0105;
        mem[5] = 16'hBEEF;
        out_ready = 1'b0;
        tick(2);
        check_eq("t5_pre_valid", 32'(out_valid), 32'h1);
        #2 rst = 1'b0;
        #1;
        check_eq("t5_async_valid", 32'(out_valid), 32'h0);
        check_eq("t5_async_out", 32'(out), 32'h0);
        check_eq("t5_async_addr", 32'(mem_addr), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Unknown opcode.
        do_reset();
        mem[0] = 16'h7A00;
        tick(2);
`ifdef SEQ_PROC_TRAP_EN
        check_eq("t6_trap", 32'(trap), 32'h1);
        check_eq("t6_halted", 32'(halted), 32'h1);
        check_eq("t6_pc", 32'(mem_addr), 32'h0);
`else
        check_eq("t6_halted", 32'(halted), 32'h0);
        check_eq("t6_pc", 32'(mem_addr), 32'h1);
`endif

        // Random programs against the interpreter.
        for (int prog = 0; prog < 12; prog++) begin
            do_reset();
            for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
            for (int i = 0; i < PROG_LEN; i++) mem[i] = rand_instr();
            m_pc = 0;
            m_acc = 16'h0000;
            m_halt = 1'b0;
            m_trap = 1'b0;
            stalled_prev = 1'b0;
            prev_out = 16'h0000;
            prev_addr = 8'h00;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                @(negedge clk);
                if (halted) break;
                en = ($urandom_range(0, 9) != 0);
                out_ready = (cyc > 2000) ? 1'b1 : 1'($urandom_range(0, 1));
                if (stalled_prev) begin
                    check_eq("rand_stall_valid", 32'(out_valid), 32'h1);
                    check_eq("rand_stall_out", 32'(out), 32'(prev_out));
                    check_eq("rand_stall_addr", 32'(mem_addr), 32'(prev_addr));
                end
                if (out_valid && out_ready) begin
                    model_next(got, exp_v);
                    check_eq("rand_has_out", 32'(got), 32'h1);
                    check_eq("rand_out", 32'(out), 32'(exp_v));
                end
                stalled_prev = out_valid && !out_ready;
                prev_out = out;
                prev_addr = mem_addr;
            end
            if (halted) begin
                model_next(got, exp_v);
                check_eq("rand_tail_out", 32'(got), 32'h0);
                check_eq("rand_halt", 32'(m_halt), 32'h1);
                check_eq("rand_halt_pc", 32'(mem_addr), 32'(m_pc));
`ifdef SEQ_PROC_TRAP_EN
                check_eq("rand_trap", 32'(trap), 32'(m_trap));
`endif
            end else begin
                check_eq("rand_nohalt", 32'(m_halt), 32'h0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
